// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch and load/store requests onto an 8-bit synchronous RAM.
// Optional build macro MEM_IO_STALL_EN adds in_io_buffer_full to hold back stores into the I/O region.
module mem_ctrl #(
    parameter logic [31:0] IO_ADDR_BASE = 32'h0003_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_rollback,
    input  logic        in_if_ena,
    input  logic [31:0] in_if_addr,
    output logic        out_if_ready,
    output logic [31:0] out_if_data,
    input  logic        in_ls_ena,
    input  logic        in_ls_write,
    input  logic [2:0]  in_ls_size,
    input  logic [31:0] in_ls_addr,
    input  logic [31:0] in_ls_data,
    output logic        out_ls_ready,
    output logic [31:0] out_ls_data,
    output logic        out_ram_rw,
    output logic [31:0] out_ram_addr,
    output logic [7:0]  out_ram_data,
    input  logic [7:0]  in_ram_data
`ifdef MEM_IO_STALL_EN
    ,
    input  logic        in_io_buffer_full
`endif
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_READ = 2'd1, ST_WRITE = 2'd2} state_t;

    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    get_byte = w[7:0];
            2'd1:    get_byte = w[15:8];
            2'd2:    get_byte = w[23:16];
            default: get_byte = w[31:24];
        endcase
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx, input logic [7:0] b);
        put_byte = w;
        case (idx)
            2'd0:    put_byte[7:0]   = b;
            2'd1:    put_byte[15:8]  = b;
            2'd2:    put_byte[23:16] = b;
            default: put_byte[31:24] = b;
        endcase
    endfunction

    // Sizes other than 1 and 2 run as full words.
    function automatic logic [2:0] size_to_n(input logic [2:0] sz);
        case (sz)
            3'd1:    size_to_n = 3'd1;
            3'd2:    size_to_n = 3'd2;
            default: size_to_n = 3'd4;
        endcase
    endfunction

    state_t      state_r, state_s;
    logic [2:0]  step_r, n_r, step_nx_s;
    logic [31:0] base_r, wdata_r, res_r, cap_word_s;
    logic        is_if_r;
    logic        if_pend_r, ls_pend_r, ls_write_r;
    logic [31:0] if_addr_r, ls_addr_r, ls_data_r;
    logic [2:0]  ls_size_r;
    logic        if_req_s, ls_req_s, if_have_s, ls_have_s, ls_write_eff_s, ls_blocked_s, io_full_s;
    logic [31:0] if_addr_eff_s, ls_addr_eff_s, ls_data_eff_s;
    logic [2:0]  ls_size_eff_s;
    logic        acc_if_s, acc_ls_s, done_s;
    logic        ram_rw_s, if_ready_s, ls_ready_s;
    logic [31:0] ram_addr_s;
    logic [7:0]  ram_data_s;
    logic        ram_rw_r, if_ready_r, ls_ready_r;
    logic [31:0] ram_addr_r, if_data_r, ls_rdata_r;
    logic [7:0]  ram_data_r;

    // A pulse in this cycle counts as pending and overrides the latched fields; rollback drops it.
    assign if_req_s       = in_if_ena & ~in_rollback;
    assign ls_req_s       = in_ls_ena & ~in_rollback;
    assign if_have_s      = if_pend_r | if_req_s;
    assign ls_have_s      = ls_pend_r | ls_req_s;
    assign if_addr_eff_s  = if_req_s ? in_if_addr  : if_addr_r;
    assign ls_addr_eff_s  = ls_req_s ? in_ls_addr  : ls_addr_r;
    assign ls_data_eff_s  = ls_req_s ? in_ls_data  : ls_data_r;
    assign ls_size_eff_s  = ls_req_s ? in_ls_size  : ls_size_r;
    assign ls_write_eff_s = ls_req_s ? in_ls_write : ls_write_r;
`ifdef MEM_IO_STALL_EN
    assign io_full_s = in_io_buffer_full;
`else
    assign io_full_s = 1'b0;
`endif
    assign ls_blocked_s = ls_write_eff_s & (ls_addr_eff_s >= IO_ADDR_BASE) & io_full_s;
    assign step_nx_s    = step_r + 3'd1;
    // RAM data now belongs to the byte addressed one cycle earlier.
    assign cap_word_s   = put_byte(res_r, step_r[1:0] - 2'd1, in_ram_data);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_s;
    end

    // Next-state logic and arbitration (LSB ahead of fetch).
    always_comb begin
        state_s  = state_r;
        acc_if_s = 1'b0;
        acc_ls_s = 1'b0;
        done_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_rollback) begin
                    state_s = ST_IDLE;
                end else if (ls_have_s && !ls_blocked_s) begin
                    acc_ls_s = 1'b1;
                    state_s  = ls_write_eff_s ? ST_WRITE : ST_READ;
                end else if (if_have_s) begin
                    acc_if_s = 1'b1;
                    state_s  = ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (in_rollback) begin
                    state_s = ST_IDLE;
                end else if (step_r == n_r) begin
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_WRITE: begin
                if (step_nx_s >= n_r) begin
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WRITE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered RAM and ready outputs.
    always_comb begin
        ram_rw_s   = 1'b0;
        ram_addr_s = 32'd0;
        ram_data_s = 8'd0;
        if_ready_s = 1'b0;
        ls_ready_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (acc_ls_s) begin
                    ram_rw_s   = ls_write_eff_s;
                    ram_addr_s = ls_addr_eff_s;
                    ram_data_s = ls_write_eff_s ? ls_data_eff_s[7:0] : 8'd0;
                end else if (acc_if_s) begin
                    ram_addr_s = if_addr_eff_s;
                end else begin
                    ram_addr_s = 32'd0;
                end
            end
            ST_READ: begin
                if (done_s) begin
                    if_ready_s = is_if_r;
                    ls_ready_s = ~is_if_r;
                end else if (!in_rollback && (step_nx_s < n_r)) begin
                    ram_addr_s = base_r + {29'd0, step_nx_s};
                end else begin
                    ram_addr_s = 32'd0;
                end
            end
            ST_WRITE: begin
                if (done_s) begin
                    ls_ready_s = 1'b1;
                end else begin
                    ram_rw_s   = 1'b1;
                    ram_addr_s = base_r + {29'd0, step_nx_s};
                    ram_data_s = get_byte(wdata_r, step_nx_s[1:0]);
                end
            end
            default: ram_rw_s = 1'b0;
        endcase
    end

    // Transaction datapath: byte counter, base address and word assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_r  <= 3'd0;
            n_r     <= 3'd0;
            base_r  <= 32'd0;
            wdata_r <= 32'd0;
            res_r   <= 32'd0;
            is_if_r <= 1'b0;
        end else if (acc_ls_s || acc_if_s) begin
            step_r  <= 3'd0;
            n_r     <= acc_ls_s ? size_to_n(ls_size_eff_s) : 3'd4;
            base_r  <= acc_ls_s ? ls_addr_eff_s : if_addr_eff_s;
            wdata_r <= ls_data_eff_s;
            res_r   <= 32'd0;
            is_if_r <= acc_if_s;
        end else if (state_r == ST_READ) begin
            step_r <= step_nx_s;
            res_r  <= (step_r != 3'd0) ? cap_word_s : res_r;
        end else if (state_r == ST_WRITE) begin
            step_r <= step_nx_s;
        end else begin
            step_r <= 3'd0;
        end
    end

    // Pending request latches, one per client.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_pend_r  <= 1'b0;
            if_addr_r  <= 32'd0;
            ls_pend_r  <= 1'b0;
            ls_write_r <= 1'b0;
            ls_size_r  <= 3'd0;
            ls_addr_r  <= 32'd0;
            ls_data_r  <= 32'd0;
        end else begin
            if (in_rollback || acc_if_s) begin
                if_pend_r <= 1'b0;
            end else if (in_if_ena) begin
                if_pend_r <= 1'b1;
                if_addr_r <= in_if_addr;
            end else begin
                if_pend_r <= if_pend_r;
            end
            // A latched store survives rollback; a latched load does not.
            if (in_rollback) begin
                ls_pend_r <= ls_pend_r & ls_write_r;
            end else if (acc_ls_s) begin
                ls_pend_r <= 1'b0;
            end else if (in_ls_ena) begin
                ls_pend_r  <= 1'b1;
                ls_write_r <= in_ls_write;
                ls_size_r  <= in_ls_size;
                ls_addr_r  <= in_ls_addr;
                ls_data_r  <= in_ls_data;
            end else begin
                ls_pend_r <= ls_pend_r;
            end
        end
    end

    // Output registers; returned data holds until the next completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_rw_r   <= 1'b0;
            ram_addr_r <= 32'd0;
            ram_data_r <= 8'd0;
            if_ready_r <= 1'b0;
            ls_ready_r <= 1'b0;
            if_data_r  <= 32'd0;
            ls_rdata_r <= 32'd0;
        end else begin
            ram_rw_r   <= ram_rw_s;
            ram_addr_r <= ram_addr_s;
            ram_data_r <= ram_data_s;
            if_ready_r <= if_ready_s;
            ls_ready_r <= ls_ready_s;
            if_data_r  <= if_ready_s ? cap_word_s : if_data_r;
            ls_rdata_r <= (ls_ready_s && state_r == ST_READ) ? cap_word_s : ls_rdata_r;
        end
    end

    assign out_ram_rw   = ram_rw_r;
    assign out_ram_addr = ram_addr_r;
    assign out_ram_data = ram_data_r;
    assign out_if_ready = if_ready_r;
    assign out_if_data  = if_data_r;
    assign out_ls_ready = ls_ready_r;
    assign out_ls_data  = ls_rdata_r;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: vector table plus corner sequences, against a ROM-backed RAM model.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, in_rollback, in_if_ena, in_ls_ena, in_ls_write;
    logic [31:0] in_if_addr, in_ls_addr, in_ls_data;
    logic [2:0]  in_ls_size;
    logic        out_if_ready, out_ls_ready, out_ram_rw;
    logic [31:0] out_if_data, out_ls_data, out_ram_addr;
    logic [7:0]  out_ram_data, ram_q;
`ifdef MEM_IO_STALL_EN
    logic        in_io_buffer_full;
`endif

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .in_rollback(in_rollback),
        .in_if_ena(in_if_ena), .in_if_addr(in_if_addr),
        .out_if_ready(out_if_ready), .out_if_data(out_if_data),
        .in_ls_ena(in_ls_ena), .in_ls_write(in_ls_write), .in_ls_size(in_ls_size),
        .in_ls_addr(in_ls_addr), .in_ls_data(in_ls_data),
        .out_ls_ready(out_ls_ready), .out_ls_data(out_ls_data),
        .out_ram_rw(out_ram_rw), .out_ram_addr(out_ram_addr), .out_ram_data(out_ram_data),
        .in_ram_data(ram_q)
`ifdef MEM_IO_STALL_EN
        , .in_io_buffer_full(in_io_buffer_full)
`endif
    );

    // RAM contents: a few fixed bytes, otherwise an address hash.
    function automatic logic [7:0] rom(input logic [31:0] a);
        case (a)
            32'h100: rom = 8'h13;
            32'h101: rom = 8'h00;
            32'h102: rom = 8'h50;
            32'h103: rom = 8'h00;
            32'h020: rom = 8'hFF;
            default: rom = a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a, input int n);
        logic [31:0] r;
        r = 32'd0;
        for (int j = 0; j < n; j++) r[8*j +: 8] = rom(a + 32'(j));
        return r;
    endfunction

    // Synchronous read: data for the address of this cycle appears next cycle.
    always @(posedge clk) ram_q <= rom(out_ram_addr);

    typedef struct {
        int          kind;   // 0 fetch, 1 load, 2 store
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t        vecs[12];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] if_q[$];
    logic [31:0] ls_q[$];
    logic [31:0] last_if = 32'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic pop_chk(input string name, input bit is_if, input logic [31:0] act);
        logic [31:0] e;
        if (is_if ? (if_q.size() == 0) : (ls_q.size() == 0)) begin
            chk({name, " unexpected ready"}, 64'd1, 64'd0);
        end else begin
            e = is_if ? if_q.pop_front() : ls_q.pop_front();
            if (is_if) last_if = e;
            chk({name, " data"}, {32'd0, act}, {32'd0, e});
        end
    endtask

    // Issue one request, follow the RAM bus cycle by cycle, and compare the completion.
    task automatic do_req(input string tag, input int kind, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] wdata, input logic [31:0] exp_data, input int exp_lat,
                          input int rb_at, input bit exp_done);
        int n; bit wr; bit seen; bit rolled; logic ew; logic [31:0] ea; logic [31:0] wsh; logic [7:0] ed;
        n  = (kind == 0) ? 4 : ((size == 3'd1) ? 1 : ((size == 3'd2) ? 2 : 4));
        wr = (kind == 2);
        if (exp_done && !wr) begin
            if (kind == 0) if_q.push_back(exp_data);
            else           ls_q.push_back(exp_data);
        end
        @(negedge clk);
        if (kind == 0) begin
            in_if_ena = 1'b1; in_if_addr = addr;
        end else begin
            in_ls_ena = 1'b1; in_ls_write = wr; in_ls_size = size; in_ls_addr = addr; in_ls_data = wdata;
        end
        @(negedge clk);
        in_if_ena = 1'b0; in_ls_ena = 1'b0;
        seen = 1'b0; rolled = 1'b0;
        for (int m = 0; m < exp_lat + 4 && !seen; m++) begin
            if (m < n && !(rolled && !wr)) begin
                ew  = wr;
                ea  = addr + 32'(m);
                wsh = wdata >> (8 * m);
                ed  = wr ? wsh[7:0] : 8'h00;
            end else begin
                ew = 1'b0; ea = 32'd0; ed = 8'h00;
            end
            chk({tag, " ram bus"}, {23'd0, out_ram_rw, out_ram_addr, out_ram_data}, {23'd0, ew, ea, ed});
            if ((kind == 0) ? out_if_ready : out_ls_ready) begin
                seen = 1'b1;
                chk({tag, " latency"}, 64'(m), 64'(exp_lat));
                if (!wr && exp_done) pop_chk(tag, kind == 0, (kind == 0) ? out_if_data : out_ls_data);
            end
            if (m == rb_at) begin
                in_rollback = 1'b1; rolled = 1'b1;
            end
            @(negedge clk);
            in_rollback = 1'b0;
        end
        chk({tag, " completion seen"}, {63'd0, seen}, {63'd0, exp_done});
    endtask

    initial begin
        int ls_at; int if_at; int cnt;
        vecs[0]  = '{0, 32'h0000_0100, 3'd0, 32'd0,          32'h0050_0013,               5};
        vecs[1]  = '{1, 32'h0000_0020, 3'd1, 32'd0,          32'h0000_00FF,               2};
        vecs[2]  = '{2, 32'h0000_0040, 3'd2, 32'hABCD_1234,  32'd0,                       2};
        vecs[3]  = '{1, 32'h0000_0044, 3'd2, 32'd0,          exp_read(32'h44, 2),         3};
        vecs[4]  = '{1, 32'hFFFF_FFFE, 3'd4, 32'd0,          exp_read(32'hFFFF_FFFE, 4),  5};
        vecs[5]  = '{2, 32'h0000_0080, 3'd4, 32'hDEAD_BEEF,  32'd0,                       4};
        vecs[6]  = '{2, 32'h0000_0090, 3'd1, 32'h0000_0055,  32'd0,                       1};
        vecs[7]  = '{1, 32'h0000_0060, 3'd3, 32'd0,          exp_read(32'h60, 4),         5};
        vecs[8]  = '{0, 32'h0000_0200, 3'd0, 32'd0,          exp_read(32'h200, 4),        5};
        vecs[9]  = '{1, 32'h0000_0070, 3'd0, 32'd0,          exp_read(32'h70, 4),         5};
        vecs[10] = '{2, 32'h0003_0000, 3'd1, 32'h0000_0041,  32'd0,                       1};
        vecs[11] = '{1, 32'h0003_0004, 3'd7, 32'd0,          exp_read(32'h3_0004, 4),     5};

        rst = 1'b1; in_rollback = 1'b0; in_if_ena = 1'b0; in_ls_ena = 1'b0; in_ls_write = 1'b0;
        in_if_addr = 32'd0; in_ls_addr = 32'd0; in_ls_data = 32'd0; in_ls_size = 3'd0;
`ifdef MEM_IO_STALL_EN
        in_io_buffer_full = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset ram bus", {23'd0, out_ram_rw, out_ram_addr, out_ram_data}, 64'd0);
        chk("reset readies", {62'd0, out_if_ready, out_ls_ready}, 64'd0);
        chk("reset data", {out_if_data, out_ls_data}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++)
            do_req($sformatf("vec%0d", i), vecs[i].kind, vecs[i].addr, vecs[i].size, vecs[i].wdata,
                   vecs[i].exp_data, vecs[i].exp_lat, -1, 1'b1);

        // Same-cycle fetch and load: load first, fetch after one idle cycle.
        ls_q.push_back(32'h0000_00FF);
        if_q.push_back(exp_read(32'h0, 4));
        @(negedge clk);
        in_if_ena = 1'b1; in_if_addr = 32'h0;
        in_ls_ena = 1'b1; in_ls_write = 1'b0; in_ls_size = 3'd1; in_ls_addr = 32'h20;
        @(negedge clk);
        in_if_ena = 1'b0; in_ls_ena = 1'b0;
        ls_at = -1; if_at = -1;
        for (int m = 0; m < 16; m++) begin
            if (out_ls_ready) begin ls_at = m; pop_chk("arb load", 1'b0, out_ls_data); end
            if (out_if_ready) begin if_at = m; pop_chk("arb fetch", 1'b1, out_if_data); end
            @(negedge clk);
        end
        chk("arb load cycle", 64'(ls_at), 64'd2);
        chk("arb fetch cycle", 64'(if_at), 64'd8);

        do_req("rb fetch", 0, 32'h100, 3'd0, 32'd0, 32'd0, 5, 2, 1'b0);
        chk("fetch data hold", {32'd0, out_if_data}, {32'd0, last_if});
        do_req("rb store", 2, 32'hC0, 3'd4, 32'h1122_3344, 32'd0, 4, 1, 1'b1);

        // A pulse on the rollback cycle is dropped.
        @(negedge clk);
        in_if_ena = 1'b1; in_if_addr = 32'h100; in_rollback = 1'b1;
        @(negedge clk);
        in_if_ena = 1'b0; in_rollback = 1'b0;
        cnt = 0;
        for (int m = 0; m < 10; m++) begin
            if (out_if_ready || out_ram_addr != 32'd0) cnt++;
            @(negedge clk);
        end
        chk("dropped request activity", 64'(cnt), 64'd0);

`ifdef MEM_IO_STALL_EN
        in_io_buffer_full = 1'b1;
        @(negedge clk);
        in_ls_ena = 1'b1; in_ls_write = 1'b1; in_ls_size = 3'd1; in_ls_addr = 32'h3_0000; in_ls_data = 32'h41;
        @(negedge clk);
        in_ls_ena = 1'b0;
        cnt = 0;
        for (int m = 0; m < 6; m++) begin
            if (out_ram_rw || out_ls_ready) cnt++;
            @(negedge clk);
        end
        chk("io stall held", 64'(cnt), 64'd0);
        in_io_buffer_full = 1'b0;
        @(negedge clk);
        chk("io store write", {23'd0, out_ram_rw, out_ram_addr, out_ram_data}, {23'd0, 1'b1, 32'h3_0000, 8'h41});
        @(negedge clk);
        chk("io store ready", {62'd0, out_ls_ready, out_ram_rw}, {62'd0, 1'b1, 1'b0});
`endif

        // Reset in the middle of a fetch: no completion afterwards.
        @(negedge clk);
        in_if_ena = 1'b1; in_if_addr = 32'h200;
        @(negedge clk);
        in_if_ena = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid reset outputs", {31'd0, out_ram_rw, out_ram_addr} | {32'd0, out_if_data}, 64'd0);
        cnt = 0;
        for (int m = 0; m < 8; m++) begin
            if (out_if_ready || out_ls_ready || out_ram_addr != 32'd0) cnt++;
            @(negedge clk);
        end
        chk("mid reset quiet", 64'(cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
